period_autorange: RTL and testbench

- Controller that sequences the frequency counter's measurement window.
- Watches each completed measurement (tens/units digits plus update strobe) and drives the counter's period/period_load configuration port.
- Steps through a fixed table of gate periods so readings stay inside a displayable window, with hysteresis.
- Also arbitrates a host period-load request against the automatic ranging. Sits between the top level/host and frequency_counter.

---
 rtl/freq_counter_pkg.sv | 37 +++
 rtl/period_autorange_if.sv | 34 +++
 rtl/period_autorange.sv | 156 +++++++++++++++
 tb/tb_period_autorange.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared constants and types for the frequency counter and its period auto-ranger.
// Holds the gate-period table, the default range index, the ranging FSM state
// encoding and the threshold/hysteresis defaults. The counter's UPDATE_PERIOD
// default should reference PERIOD_R1 from here.
package freq_counter_pkg;

  // Gate periods in clocks; index 0 is the longest (lowest-frequency) range.
  localparam int unsigned PERIOD_R0 = 4000;
  localparam int unsigned PERIOD_R1 = 1200;
  localparam int unsigned PERIOD_R2 = 400;
  localparam int unsigned PERIOD_R3 = 120;

  localparam logic [1:0] DEFAULT_RANGE = 2'd1;

  localparam int unsigned HIGH_THRESH_DEF = 90;
  localparam int unsigned LOW_THRESH_DEF  = 9;
  localparam int unsigned HYST_DEF        = 2;

  typedef enum logic [1:0] {
    StInit,
    StSettle,
    StMeasure,
    StLoad
  } ar_state_e;

  function automatic int unsigned period_of(logic [1:0] idx);
    int unsigned p;
    case (idx)
      2'd0:    p = PERIOD_R0;
      2'd1:    p = PERIOD_R1;
      2'd2:    p = PERIOD_R2;
      default: p = PERIOD_R3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/period_autorange_if.sv
// Bundle between the host/measurement side and the period auto-ranger.
//   meas_valid/meas_tens/meas_units : completed measurement (BCD digits + strobe)
//   auto_en                         : automatic ranging enable
//   host_period/host_load           : host period override request
//   period/period_load              : configuration port towards the counter
//   range_idx/range_change/locked   : ranging status
// slave = the ranger, master = whoever drives measurements and host requests.
interface period_autorange_if #(
  parameter int unsigned BITS = 12
) ();

  logic            meas_valid;
  logic [3:0]      meas_tens;
  logic [3:0]      meas_units;
  logic            auto_en;
  logic [BITS-1:0] host_period;
  logic            host_load;
  logic [BITS-1:0] period;
  logic            period_load;
  logic [1:0]      range_idx;
  logic            range_change;
  logic            locked;

  modport master (
    output meas_valid, meas_tens, meas_units, auto_en, host_period, host_load,
    input  period, period_load, range_idx, range_change, locked
  );

  modport slave (
    input  meas_valid, meas_tens, meas_units, auto_en, host_period, host_load,
    output period, period_load, range_idx, range_change, locked
  );

endinterface

// File: rtl/period_autorange.sv
// Gate-period auto-ranger for the frequency counter.
// Watches completed measurements and steps through a fixed period table so the
// two-digit reading stays in a displayable window, with hysteresis. A host
// period load overrides the automatic choice until the next range change.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : period_autorange_if.slave (measurement in, host request in,
//           period/period_load and status out); all outputs registered.
module period_autorange
  import freq_counter_pkg::*;
#(
  parameter int unsigned BITS        = 12,
  parameter int unsigned NUM_RANGES  = 4,
  parameter int unsigned HYST        = HYST_DEF,
  parameter int unsigned HIGH_THRESH = HIGH_THRESH_DEF,
  parameter int unsigned LOW_THRESH  = LOW_THRESH_DEF
) (
  input logic               clk,
  input logic               reset,
  period_autorange_if.slave bus
);

  localparam int unsigned CW      = $clog2(HYST + 1);
  localparam logic [1:0]  MAX_IDX = 2'(NUM_RANGES - 1);
  localparam logic [7:0]  HI_TH   = 8'(HIGH_THRESH);
  localparam logic [7:0]  LO_TH   = 8'(LOW_THRESH);

  ar_state_e       state_q, state_d;
  logic [BITS-1:0] period_q, period_d;
  logic            period_load_q, period_load_d;
  logic [1:0]      range_idx_q, range_idx_d;
  logic            range_change_q, range_change_d;
  logic            locked_q, locked_d;
  logic [CW-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CW-1:0]   lo_cnt_q, lo_cnt_d;
  logic [1:0]      new_idx_q, new_idx_d;
  // A host load seen during INIT is held here and issued right after INIT's load.
  logic            host_pend_q, host_pend_d;
  logic [BITS-1:0] host_val_q, host_val_d;

  logic [7:0] reading;

  // Plain binary weighting; digits above 9 are used as-is (max 165).
  assign reading = ({4'd0, bus.meas_tens} * 8'd10) + {4'd0, bus.meas_units};

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_load_d  = 1'b0;
    range_idx_d    = range_idx_q;
    range_change_d = 1'b0;
    locked_d       = locked_q;
    hi_cnt_d       = hi_cnt_q;
    lo_cnt_d       = lo_cnt_q;
    new_idx_d      = new_idx_q;
    host_pend_d    = host_pend_q;
    host_val_d     = host_val_q;

    if (state_q == StInit) begin
      period_d      = BITS'(period_of(range_idx_q));
      period_load_d = 1'b1;
      state_d       = StSettle;
      if (bus.host_load) begin
        host_pend_d = 1'b1;
        host_val_d  = bus.host_period;
      end
    end else if (bus.host_load || host_pend_q) begin
      // Host wins over any measurement or pending range change this cycle.
      period_d      = bus.host_load ? bus.host_period : host_val_q;
      period_load_d = 1'b1;
      hi_cnt_d      = '0;
      lo_cnt_d      = '0;
      host_pend_d   = 1'b0;
      state_d       = StSettle;
    end else begin
      case (state_q)
        StSettle: begin
          // First reading after a period change spans both periods: drop it.
          if (bus.meas_valid) state_d = StMeasure;
        end
        StMeasure: begin
          if (bus.meas_valid) begin
            locked_d = (reading >= LO_TH) && (reading <= HI_TH);
            if (!bus.auto_en) begin
              hi_cnt_d = '0;
              lo_cnt_d = '0;
            end else if ((reading > HI_TH) && (range_idx_q < MAX_IDX)) begin
              hi_cnt_d = hi_cnt_q + CW'(1);
              lo_cnt_d = '0;
              if (hi_cnt_d == CW'(HYST)) begin
                new_idx_d = range_idx_q + 2'd1;
                state_d   = StLoad;
              end
            end else if ((reading < LO_TH) && (range_idx_q > 2'd0)) begin
              lo_cnt_d = lo_cnt_q + CW'(1);
              hi_cnt_d = '0;
              if (lo_cnt_d == CW'(HYST)) begin
                new_idx_d = range_idx_q - 2'd1;
                state_d   = StLoad;
              end
            end else begin
              hi_cnt_d = '0;
              lo_cnt_d = '0;
            end
          end
        end
        StLoad: begin
          range_idx_d    = new_idx_q;
          period_d       = BITS'(period_of(new_idx_q));
          period_load_d  = 1'b1;
          range_change_d = 1'b1;
          hi_cnt_d       = '0;
          lo_cnt_d       = '0;
          state_d        = StSettle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StInit;
      period_q       <= BITS'(PERIOD_R1);
      period_load_q  <= 1'b0;
      range_idx_q    <= DEFAULT_RANGE;
      range_change_q <= 1'b0;
      locked_q       <= 1'b0;
      hi_cnt_q       <= '0;
      lo_cnt_q       <= '0;
      new_idx_q      <= DEFAULT_RANGE;
      host_pend_q    <= 1'b0;
      host_val_q     <= '0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      period_load_q  <= period_load_d;
      range_idx_q    <= range_idx_d;
      range_change_q <= range_change_d;
      locked_q       <= locked_d;
      hi_cnt_q       <= hi_cnt_d;
      lo_cnt_q       <= lo_cnt_d;
      new_idx_q      <= new_idx_d;
      host_pend_q    <= host_pend_d;
      host_val_q     <= host_val_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_load  = period_load_q;
  assign bus.range_idx    = range_idx_q;
  assign bus.range_change = range_change_q;
  assign bus.locked       = locked_q;

endmodule

// File: tb/tb_period_autorange.sv
// Self-checking bench for period_autorange. Each expected period load is pushed
// to a scoreboard when its triggering stimulus is driven; a negedge monitor pops
// and compares every load the DUT issues (value, index, change flag, cycle).
module tb_period_autorange;

  logic clk;
  logic reset;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    int unsigned period;
    int unsigned idx;
    int unsigned rc;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  period_autorange_if #(.BITS(12)) bus ();

  period_autorange #(
    .BITS       (12),
    .NUM_RANGES (4),
    .HYST       (2),
    .HIGH_THRESH(90),
    .LOW_THRESH (9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_load(input int unsigned p, input int unsigned idx,
                             input int unsigned rc, input int unsigned dly);
    exp_t e;
    e.period = p;
    e.idx    = idx;
    e.rc     = rc;
    e.due    = cyc + dly;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after a rising edge and are held for one cycle.
  task automatic drive(input logic v, input logic [3:0] t, input logic [3:0] u,
                       input logic hl, input int unsigned hp);
    @(posedge clk);
    #1;
    bus.meas_valid  = v;
    bus.meas_tens   = t;
    bus.meas_units  = u;
    bus.host_load   = hl;
    bus.host_period = 12'(hp);
    @(posedge clk);
    #1;
    bus.meas_valid = 1'b0;
    bus.host_load  = 1'b0;
  endtask

  task automatic meas(input logic [3:0] t, input logic [3:0] u);
    drive(1'b1, t, u, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_period"}, bus.period, 1200);
    check_eq({pfx, "_period_load"}, bus.period_load, 0);
    check_eq({pfx, "_range_idx"}, bus.range_idx, 1);
    check_eq({pfx, "_range_change"}, bus.range_change, 0);
    check_eq({pfx, "_locked"}, bus.locked, 0);
  endtask

  // Every load must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.period_load) begin
      check_eq("load_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq("load_period", bus.period, mon_e.period);
        check_eq("load_range_idx", bus.range_idx, mon_e.idx);
        check_eq("load_range_change", bus.range_change, mon_e.rc);
        check_eq("load_cycle", cyc, mon_e.due);
      end
    end
    if (!reset && bus.range_change) check_eq("rc_with_load", bus.period_load, 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc             = 0;
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.meas_valid  = 1'b0;
    bus.meas_tens   = 4'd0;
    bus.meas_units  = 4'd0;
    bus.auto_en     = 1'b0;
    bus.host_load   = 1'b0;
    bus.host_period = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Release: single INIT load of the default range, then silence.
    reset = 1'b0;
    expect_load(1200, 1, 0, 1);
    idle(6);
    check_eq("init_range_idx", bus.range_idx, 1);

    // Step up 1 -> 2 -> 3 on readings of 95 (first reading after a load dropped).
    bus.auto_en = 1'b1;
    meas(9, 5);
    meas(9, 5);
    meas(9, 5);
    expect_load(400, 2, 1, 1);
    idle(3);
    meas(9, 5);
    meas(9, 5);
    meas(9, 5);
    expect_load(120, 3, 1, 1);
    idle(3);
    check_eq("up_range_idx", bus.range_idx, 3);

    // Top of the table: high readings cannot move it further.
    meas(9, 9);
    meas(9, 9);
    meas(9, 9);
    meas(9, 9);
    idle(3);
    check_eq("top_range_idx", bus.range_idx, 3);
    check_eq("top_locked_99", bus.locked, 0);
    meas(5, 0);
    check_eq("top_locked_50", bus.locked, 1);

    // Step back down 3 -> 2 -> 1 on readings of 5.
    meas(0, 5);
    meas(0, 5);
    expect_load(400, 2, 1, 1);
    idle(3);
    meas(0, 5);
    meas(0, 5);
    meas(0, 5);
    expect_load(1200, 1, 1, 1);
    idle(3);

    // Alternating readings keep resetting the hysteresis.
    meas(5, 0);
    meas(9, 5);
    check_eq("alt_locked_95", bus.locked, 0);
    meas(5, 0);
    check_eq("alt_locked_50", bus.locked, 1);
    meas(9, 5);
    meas(5, 0);
    idle(3);
    check_eq("alt_range_idx", bus.range_idx, 1);

    // Host load coincident with a measurement: host wins, reading dropped.
    drive(1'b1, 4'd0, 4'd5, 1'b1, 777);
    expect_load(777, 1, 0, 0);
    idle(3);
    check_eq("host_locked_kept", bus.locked, 1);
    check_eq("host_range_idx", bus.range_idx, 1);
    check_eq("host_period_held", bus.period, 777);

    // Next automatic change replaces the host period with a table value.
    meas(9, 5);
    meas(9, 5);
    meas(9, 5);
    expect_load(400, 2, 1, 1);
    idle(3);

    // Reach LOAD (heading to range 3) and reset in that cycle.
    meas(9, 5);
    meas(9, 5);
    meas(9, 5);
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    idle(1);
    check_eq("rst_hold_period_load", bus.period_load, 0);
    reset = 1'b0;
    expect_load(1200, 1, 0, 1);
    idle(6);
    check_eq("post_rst_range_idx", bus.range_idx, 1);

    check_eq("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
